cache_nway_ctrl: RTL and testbench

- Parametrised N-way set-associative, write-through, no-write-allocate cache with an integrated miss/fill and write-through state machine.
- Sits between the CPU load/store port and a single-outstanding-request memory port.
- Successor to the fixed 2-way, 64-set, 8-word cache. Adds configurable geometry, true LRU for up to 4 ways, an owned fill sequencer, flush, and a miss counter.

---
 rtl/cache_nway_ctrl.sv | 198 +++++++++++++++++++
 tb/tb_cache_nway_ctrl.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_nway_ctrl.sv
// rtl/cache_nway_ctrl.sv - N-way set-associative write-through cache with fill/write sequencer
module cache_nway_ctrl #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16,
  parameter int WORDS  = 8,
  parameter int SETS   = 64,
  parameter int WAYS   = 2
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              cpu_req_i,
  input  logic              cpu_we_i,
  input  logic [ADDR_W-1:0] cpu_addr_i,
  input  logic [DATA_W-1:0] cpu_wdata_i,
  output logic              cpu_ready_o,
  output logic [DATA_W-1:0] cpu_rdata_o,
  input  logic              flush_i,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic              mem_ack_i,
  input  logic [DATA_W-1:0] mem_rdata_i,
  output logic [15:0]       miss_count_o
);
  localparam int OFF_W  = $clog2(WORDS) + 1;
  localparam int WSEL_W = OFF_W - 1;
  localparam int IDX_W  = $clog2(SETS);
  localparam int TAG_W  = ADDR_W - IDX_W - OFF_W;
  localparam int AGE_W  = (WAYS > 1) ? $clog2(WAYS) : 1;

  typedef enum logic [1:0] {ST_IDLE, ST_FILL, ST_WRITE} state_e;

  state_e             state_q;
  logic               valid_q [WAYS][SETS];
  logic [TAG_W-1:0]   tag_q   [WAYS][SETS];
  logic [DATA_W-1:0]  data_q  [WAYS][SETS][WORDS];
  logic [AGE_W-1:0]   age_q   [WAYS][SETS];
  logic [WSEL_W-1:0]  fill_cnt_q;
  logic [AGE_W-1:0]   victim_q;
  logic [15:0]        miss_count_q;
  logic               mem_req_q;
  logic               mem_we_q;
  logic [ADDR_W-1:0]  mem_addr_q;
  logic [DATA_W-1:0]  mem_wdata_q;

  logic [TAG_W-1:0]   tag;
  logic [IDX_W-1:0]   idx;
  logic [WSEL_W-1:0]  wsel;
  logic               unused_addr0;
  logic               hit;
  logic [AGE_W-1:0]   hit_way;
  logic               any_inv;
  logic [AGE_W-1:0]   inv_way;
  logic [AGE_W-1:0]   lru_way;
  logic [AGE_W-1:0]   victim;
  logic [AGE_W-1:0]   acc_way;
  logic [AGE_W-1:0]   age_upd [WAYS];
  logic               rd_hit;
  logic               fill_last;

  assign tag          = cpu_addr_i[ADDR_W-1 -: TAG_W];
  assign idx          = cpu_addr_i[OFF_W +: IDX_W];
  assign wsel         = cpu_addr_i[1 +: WSEL_W];
  assign unused_addr0 = cpu_addr_i[0];

  // Tag compare across all ways of the addressed set
  always_comb begin
    hit     = 1'b0;
    hit_way = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (valid_q[w][idx] && (tag_q[w][idx] == tag)) begin
        hit     = 1'b1;
        hit_way = AGE_W'(w);
      end
    end
  end

  // Victim: lowest-index invalid way, else the oldest way
  always_comb begin
    any_inv = 1'b0;
    inv_way = '0;
    lru_way = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (!valid_q[w][idx]) begin
        any_inv = 1'b1;
        inv_way = AGE_W'(w);
      end
    end
    for (int w = 0; w < WAYS; w++) begin
      if (age_q[w][idx] == AGE_W'(WAYS - 1)) lru_way = AGE_W'(w);
    end
    victim = any_inv ? inv_way : lru_way;
  end

  // New ages for the set if acc_way becomes most recently used
  assign acc_way = (state_q == ST_FILL) ? victim_q : hit_way;
  always_comb begin
    for (int w = 0; w < WAYS; w++) begin
      age_upd[w] = age_q[w][idx];
      if (AGE_W'(w) == acc_way)                      age_upd[w] = '0;
      else if (age_q[w][idx] < age_q[acc_way][idx])  age_upd[w] = age_q[w][idx] + 1'b1;
    end
  end

  assign rd_hit       = (state_q == ST_IDLE) && !flush_i && cpu_req_i && !cpu_we_i && hit;
  assign fill_last    = (fill_cnt_q == WSEL_W'(WORDS - 1));
  assign cpu_ready_o  = rd_hit || ((state_q == ST_WRITE) && mem_ack_i);
  assign cpu_rdata_o  = rd_hit ? data_q[hit_way][idx][wsel] : '0;
  assign mem_req_o    = mem_req_q;
  assign mem_we_o     = mem_we_q;
  assign mem_addr_o   = mem_addr_q;
  assign mem_wdata_o  = mem_wdata_q;
  assign miss_count_o = miss_count_q;

  // Control FSM: line state, LRU ages, miss counter and registered memory request
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= ST_IDLE;
      fill_cnt_q   <= '0;
      victim_q     <= '0;
      miss_count_q <= '0;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      for (int w = 0; w < WAYS; w++) begin
        for (int s = 0; s < SETS; s++) begin
          valid_q[w][s] <= 1'b0;
          age_q[w][s]   <= AGE_W'(w);
        end
      end
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (flush_i) begin
            for (int w = 0; w < WAYS; w++) begin
              for (int s = 0; s < SETS; s++) valid_q[w][s] <= 1'b0;
            end
          end else if (cpu_req_i) begin
            if (cpu_we_i) begin
              state_q     <= ST_WRITE;
              mem_req_q   <= 1'b1;
              mem_we_q    <= 1'b1;
              mem_addr_q  <= {cpu_addr_i[ADDR_W-1:1], 1'b0};
              mem_wdata_q <= cpu_wdata_i;
            end else if (hit) begin
              for (int w = 0; w < WAYS; w++) age_q[w][idx] <= age_upd[w];
            end else begin
              state_q              <= ST_FILL;
              victim_q             <= victim;
              valid_q[victim][idx] <= 1'b0;
              fill_cnt_q           <= '0;
              miss_count_q         <= (miss_count_q == 16'hFFFF) ? miss_count_q : miss_count_q + 16'd1;
              mem_req_q            <= 1'b1;
              mem_we_q             <= 1'b0;
              mem_addr_q           <= {tag, idx, WSEL_W'(0), 1'b0};
            end
          end
        end
        ST_FILL: begin
          if (mem_ack_i) begin
            fill_cnt_q <= fill_cnt_q + 1'b1;
            mem_addr_q <= {tag, idx, fill_cnt_q + 1'b1, 1'b0};
            if (fill_last) begin
              valid_q[victim_q][idx] <= 1'b1;
              for (int w = 0; w < WAYS; w++) age_q[w][idx] <= age_upd[w];
              state_q   <= ST_IDLE;
              mem_req_q <= 1'b0;
            end
          end
        end
        ST_WRITE: begin
          if (mem_ack_i) begin
            if (hit) begin
              for (int w = 0; w < WAYS; w++) age_q[w][idx] <= age_upd[w];
            end
            state_q   <= ST_IDLE;
            mem_req_q <= 1'b0;
            mem_we_q  <= 1'b0;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Tag and data arrays: fill writes from memory, store hits write through
  always_ff @(posedge clk_i) begin
    if ((state_q == ST_FILL) && mem_ack_i) begin
      data_q[victim_q][idx][fill_cnt_q] <= mem_rdata_i;
      if (fill_last) tag_q[victim_q][idx] <= tag;
    end
    if ((state_q == ST_WRITE) && mem_ack_i && hit) begin
      data_q[hit_way][idx][wsel] <= cpu_wdata_i;
    end
  end
endmodule

// File: tb/tb_cache_nway_ctrl.sv
// tb/tb_cache_nway_ctrl.sv - self-checking bench for cache_nway_ctrl (default geometry)
module tb_cache_nway_ctrl;
  localparam int WAYS  = 2;
  localparam int WORDS = 8;

  logic        clk;
  logic        rst_n;
  logic        cpu_req;
  logic        cpu_we;
  logic [15:0] cpu_addr;
  logic [15:0] cpu_wdata;
  logic        cpu_ready_o;
  logic [15:0] cpu_rdata_o;
  logic        flush;
  logic        mem_req_o;
  logic        mem_we_o;
  logic [15:0] mem_addr_o;
  logic [15:0] mem_wdata_o;
  logic        mem_ack;
  logic [15:0] mem_rdata;
  logic [15:0] miss_count_o;

  cache_nway_ctrl dut (
    .clk_i(clk), .rst_ni(rst_n), .cpu_req_i(cpu_req), .cpu_we_i(cpu_we),
    .cpu_addr_i(cpu_addr), .cpu_wdata_i(cpu_wdata), .cpu_ready_o(cpu_ready_o),
    .cpu_rdata_o(cpu_rdata_o), .flush_i(flush), .mem_req_o(mem_req_o),
    .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
    .mem_ack_i(mem_ack), .mem_rdata_i(mem_rdata), .miss_count_o(miss_count_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic        we;
    logic [15:0] addr;
    logic [15:0] wdata;
  } txn_t;

  // Reference model: MRU-first list of cached line bases, per-word store overlay
  logic [15:0] lines[$];
  logic [15:0] line_data [logic [15:0]];
  logic [15:0] model_miss;
  txn_t        exp_q[$];

  int          n_checks = 0;
  int          n_fail   = 0;
  int          cyc      = 0;
  int          last_ack_cyc = 0;
  int          ready_cyc = 0;
  int          n_acks   = 0;
  logic        active   = 1'b0;
  logic        done     = 1'b0;
  logic        exp_we   = 1'b0;
  logic [15:0] exp_rdata = '0;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endfunction

  function automatic void model_clear();
    lines.delete();
    line_data.delete();
  endfunction

  task automatic model_access(input logic we, input logic [15:0] addr, input logic [15:0] wdata,
                              output logic hit, output logic [15:0] rdata);
    logic [15:0] wa;
    logic [15:0] base;
    logic [15:0] ev;
    int          pos;
    int          n_in_set;
    int          last_in_set;
    txn_t        t;
    wa    = addr & 16'hFFFE;
    base  = addr & 16'hFFF0;
    pos   = -1;
    rdata = '0;
    for (int i = 0; i < lines.size(); i++) if (lines[i] == base) pos = i;
    hit = (pos >= 0);
    if (hit) begin
      lines.delete(pos);
      lines.push_front(base);
    end
    if (we) begin
      t.we = 1'b1; t.addr = wa; t.wdata = wdata;
      exp_q.push_back(t);
      if (hit) line_data[wa] = wdata;
    end else begin
      if (!hit) begin
        n_in_set = 0;
        last_in_set = -1;
        for (int i = 0; i < lines.size(); i++) begin
          if (lines[i][9:4] == base[9:4]) begin
            n_in_set++;
            last_in_set = i;
          end
        end
        if (n_in_set >= WAYS) begin
          ev = lines[last_in_set];
          for (int k = 0; k < WORDS; k++) begin
            if (line_data.exists(ev + 16'(2 * k))) line_data.delete(ev + 16'(2 * k));
          end
          lines.delete(last_in_set);
        end
        lines.push_front(base);
        for (int k = 0; k < WORDS; k++) begin
          t.we = 1'b0; t.addr = base + 16'(2 * k); t.wdata = '0;
          exp_q.push_back(t);
        end
        if (model_miss != 16'hFFFF) model_miss = model_miss + 16'd1;
      end
      rdata = line_data.exists(wa) ? line_data[wa] : wa;
    end
  endtask

  // Memory responder: acks a request on its second cycle, read data = address
  initial begin
    int wcnt;
    wcnt = 0;
    mem_ack = 1'b0;
    mem_rdata = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        mem_ack = 1'b0;
        wcnt = 0;
      end else if (mem_ack) begin
        mem_ack = 1'b0;
        wcnt = 0;
      end else if (mem_req_o) begin
        wcnt++;
        if (wcnt >= 2) begin
          mem_ack = 1'b1;
          mem_rdata = mem_addr_o;
          n_acks++;
        end
      end else begin
        wcnt = 0;
      end
    end
  end

  // Compare process: memory transactions against the model, completions against expected data
  initial begin
    txn_t t;
    forever begin
      @(negedge clk);
      cyc++;
      #2;
      if (rst_n) begin
        if (mem_req_o) chk("mem_addr_bit0", {31'd0, mem_addr_o[0]}, 32'd0);
        if (mem_ack) begin
          last_ack_cyc = cyc;
          if (exp_q.size() == 0) begin
            chk("unexpected_mem_txn_addr", {16'd0, mem_addr_o}, 32'hFFFF_FFFF);
          end else begin
            t = exp_q.pop_front();
            chk("mem_req", {31'd0, mem_req_o}, 32'd1);
            chk("mem_we", {31'd0, mem_we_o}, {31'd0, t.we});
            chk("mem_addr", {16'd0, mem_addr_o}, {16'd0, t.addr});
            if (t.we) chk("mem_wdata", {16'd0, mem_wdata_o}, {16'd0, t.wdata});
          end
        end
        if (active) begin
          if (cpu_ready_o && !done) begin
            done = 1'b1;
            ready_cyc = cyc;
            if (!exp_we) chk("cpu_rdata", {16'd0, cpu_rdata_o}, {16'd0, exp_rdata});
            chk("miss_count", {16'd0, miss_count_o}, {16'd0, model_miss});
          end
        end else begin
          chk("idle_ready", {31'd0, cpu_ready_o}, 32'd0);
          chk("idle_mem_req", {31'd0, mem_req_o}, 32'd0);
        end
      end
    end
  end

  task automatic access(input logic we, input logic [15:0] addr, input logic [15:0] wdata,
                        input logic exp_hit, input logic [15:0] exp_rd, input logic [15:0] exp_mc);
    logic        h;
    logic [15:0] rd;
    int          issue;
    int          n;
    model_access(we, addr, wdata, h, rd);
    chk("model_hit", {31'd0, h}, {31'd0, exp_hit});
    if (!we) chk("model_rdata", {16'd0, rd}, {16'd0, exp_rd});
    chk("model_miss", {16'd0, model_miss}, {16'd0, exp_mc});
    exp_rdata = rd;
    exp_we    = we;
    @(negedge clk);
    cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wdata;
    done = 1'b0; active = 1'b1;
    #3;
    issue = cyc;
    n = 0;
    while (!done && n < 400) begin
      @(negedge clk);
      #3;
      n++;
    end
    if (!done) begin
      chk("timeout_cpu_ready", 32'd0, 32'd1);
    end else if (!we && h) begin
      chk("hit_latency", ready_cyc - issue, 32'd0);
    end else if (!we) begin
      chk("miss_latency_after_last_ack", ready_cyc - last_ack_cyc, 32'd1);
    end
    @(negedge clk);
    cpu_req = 1'b0; active = 1'b0;
    chk("mem_txns_drained", exp_q.size(), 32'd0);
  endtask

  task automatic do_flush_with_req(input logic [15:0] addr);
    @(negedge clk);
    flush = 1'b1; cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = addr;
    #3;
    chk("flush_blocks_ready", {31'd0, cpu_ready_o}, 32'd0);
    @(negedge clk);
    flush = 1'b0; cpu_req = 1'b0;
    model_clear();
  endtask

  task automatic reset_mid_fill(input logic [15:0] addr);
    logic        h;
    logic [15:0] rd;
    int          n0;
    int          n;
    model_access(1'b0, addr, 16'h0, h, rd);
    chk("model_hit_pre_reset", {31'd0, h}, 32'd0);
    chk("model_miss_pre_reset", {16'd0, model_miss}, 32'd7);
    @(negedge clk);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = addr;
    done = 1'b0; active = 1'b1;
    n0 = n_acks;
    n = 0;
    while ((n_acks - n0) < 4 && n < 400) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk("fourth_fill_ack_seen", n_acks - n0, 32'd4);
    chk("mem_req_before_reset", {31'd0, mem_req_o}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("rst_cpu_ready", {31'd0, cpu_ready_o}, 32'd0);
    chk("rst_cpu_rdata", {16'd0, cpu_rdata_o}, 32'd0);
    chk("rst_mem_req", {31'd0, mem_req_o}, 32'd0);
    chk("rst_mem_we", {31'd0, mem_we_o}, 32'd0);
    chk("rst_mem_addr", {16'd0, mem_addr_o}, 32'd0);
    chk("rst_mem_wdata", {16'd0, mem_wdata_o}, 32'd0);
    chk("rst_miss_count", {16'd0, miss_count_o}, 32'd0);
    cpu_req = 1'b0; active = 1'b0;
    model_clear();
    exp_q.delete();
    model_miss = '0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0; flush = 1'b0;
    model_miss = '0;
    @(negedge clk);
    #1;
    chk("reset_cpu_ready", {31'd0, cpu_ready_o}, 32'd0);
    chk("reset_mem_req", {31'd0, mem_req_o}, 32'd0);
    chk("reset_mem_addr", {16'd0, mem_addr_o}, 32'd0);
    chk("reset_miss_count", {16'd0, miss_count_o}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    access(1'b0, 16'h0046, 16'h0000, 1'b0, 16'h0046, 16'd1);
    access(1'b0, 16'h004A, 16'h0000, 1'b1, 16'h004A, 16'd1);
    access(1'b0, 16'h0440, 16'h0000, 1'b0, 16'h0440, 16'd2);
    access(1'b0, 16'h0040, 16'h0000, 1'b1, 16'h0040, 16'd2);
    access(1'b0, 16'h0840, 16'h0000, 1'b0, 16'h0840, 16'd3);
    access(1'b0, 16'h0040, 16'h0000, 1'b1, 16'h0040, 16'd3);
    access(1'b0, 16'h0440, 16'h0000, 1'b0, 16'h0440, 16'd4);
    access(1'b1, 16'h0042, 16'h1234, 1'b1, 16'h0000, 16'd4);
    access(1'b0, 16'h0042, 16'h0000, 1'b1, 16'h1234, 16'd4);
    access(1'b1, 16'h2000, 16'hBEEF, 1'b0, 16'h0000, 16'd4);
    access(1'b0, 16'h2000, 16'h0000, 1'b0, 16'h2000, 16'd5);

    do_flush_with_req(16'h004A);
    access(1'b0, 16'h0040, 16'h0000, 1'b0, 16'h0040, 16'd6);
    access(1'b0, 16'h0042, 16'h0000, 1'b1, 16'h0042, 16'd6);
    access(1'b1, 16'h0043, 16'h5555, 1'b1, 16'h0000, 16'd6);
    access(1'b0, 16'h0042, 16'h0000, 1'b1, 16'h5555, 16'd6);

    reset_mid_fill(16'h0846);
    access(1'b0, 16'h0846, 16'h0000, 1'b0, 16'h0846, 16'd1);

    @(negedge clk);
    force dut.miss_count_q = 16'hFFFF;
    @(negedge clk);
    release dut.miss_count_q;
    model_miss = 16'hFFFF;
    #2;
    chk("miss_count_preload", {16'd0, miss_count_o}, 32'h0000FFFF);
    access(1'b0, 16'h0040, 16'h0000, 1'b0, 16'h0040, 16'hFFFF);
    access(1'b0, 16'h0040, 16'h0000, 1'b1, 16'h0040, 16'hFFFF);

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
